// File: rtl/control_sequencer_if.sv
// Control strobe bundle between the hardwired sequencer and the phase-1 datapath.
// The datapath supplies the instruction register contents and a halt request.
// The sequencer drives the per-cycle strobes back to it, together with Run and State.
//   master : sequencer side (drives strobes, reads IR/Stop)
//   slave  : datapath side  (drives IR/Stop, reads strobes)
interface control_sequencer_if;
   logic [31:0] IR;
   logic        Stop;

   logic        PCout;
   logic        ZHIout;
   logic        ZLOout;
   logic        MDRout;

   logic        MARin;
   logic        Zin;
   logic        PCin;
   logic        MDRin;
   logic        IRin;
   logic        Yin;
   logic        HIin;
   logic        LOin;

   logic        IncrementPC;
   logic        Read;

   logic        Gra;
   logic        Grb;
   logic        Grc;
   logic        Rin;
   logic        Rout;

   logic [4:0]  ALUControl;
   logic        Run;
   logic [3:0]  State;

   modport master (
      input  IR, Stop,
      output PCout, ZHIout, ZLOout, MDRout,
      output MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin,
      output IncrementPC, Read,
      output Gra, Grb, Grc, Rin, Rout,
      output ALUControl, Run, State
   );

   modport slave (
      output IR, Stop,
      input  PCout, ZHIout, ZLOout, MDRout,
      input  MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin,
      input  IncrementPC, Read,
      input  Gra, Grb, Grc, Rin, Rout,
      input  ALUControl, Run, State
   );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the phase-1 datapath.
// Ports:
//   Clock : system clock, rising-edge active
//   Clear : asynchronous active-low reset
//   bus   : control_sequencer_if.master (IR/Stop in; strobes, ALUControl, Run, State out)
//
// state | meaning
// ------+---------------------------------------------------------------
// RESET | held by Clear; leaves to T0 on the first edge with Clear high
// T0    | fetch: PC -> MAR, PC+1 -> Z
// T1    | Z -> PC, memory read into MDR
// T2    | MDR -> IR; dispatch on opcode class
// T3    | Rb -> Y
// T4    | Y op Rc -> Z (ALUControl = opcode)
// T5    | ZLO -> Ra (ALU class) or ZLO -> LO (mul/div)
// T6    | ZHI -> HI (mul/div only)
// HALT  | parked, all strobes low; only Clear leaves
module control_sequencer #(
   parameter logic [4:0] OP_MUL  = 5'b01111,
   parameter logic [4:0] OP_DIV  = 5'b10000,
   parameter logic [4:0] OP_NOP  = 5'b11010,
   parameter logic [4:0] OP_HALT = 5'b11011
) (
   input  logic                 Clock,
   input  logic                 Clear,
   control_sequencer_if.master  bus
);

   typedef enum logic [3:0] {
      S_RESET = 4'd0,
      S_T0    = 4'd1,
      S_T1    = 4'd2,
      S_T2    = 4'd3,
      S_T3    = 4'd4,
      S_T4    = 4'd5,
      S_T5    = 4'd6,
      S_T6    = 4'd7,
      S_HALT  = 4'd8
   } state_t;

   state_t     state_q;
   state_t     state_d;
   state_t     boundary_next;
   logic [4:0] op;
   logic       is_alu;
   logic       is_md;
   logic       is_halt;

   assign op      = bus.IR[31:27];
   assign is_alu  = (op <= 5'd8);
   assign is_md   = (op == OP_MUL) || (op == OP_DIV);
   assign is_halt = (op == OP_HALT);

   // Every path into T0 is an instruction boundary where a halt request is honoured.
   assign boundary_next = bus.Stop ? S_HALT : S_T0;

   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         state_q <= S_RESET;
      end else begin
         state_q <= state_d;
      end
   end

   assign bus.State = state_q;

   always_comb begin
      state_d         = state_q;
      bus.PCout       = 1'b0;
      bus.ZHIout      = 1'b0;
      bus.ZLOout      = 1'b0;
      bus.MDRout      = 1'b0;
      bus.MARin       = 1'b0;
      bus.Zin         = 1'b0;
      bus.PCin        = 1'b0;
      bus.MDRin       = 1'b0;
      bus.IRin        = 1'b0;
      bus.Yin         = 1'b0;
      bus.HIin        = 1'b0;
      bus.LOin        = 1'b0;
      bus.IncrementPC = 1'b0;
      bus.Read        = 1'b0;
      bus.Gra         = 1'b0;
      bus.Grb         = 1'b0;
      bus.Grc         = 1'b0;
      bus.Rin         = 1'b0;
      bus.Rout        = 1'b0;
      bus.ALUControl  = 5'd0;
      bus.Run         = 1'b0;

      case (state_q)
         S_RESET: begin
            state_d = S_T0;
         end
         S_T0: begin
            bus.Run         = 1'b1;
            bus.PCout       = 1'b1;
            bus.MARin       = 1'b1;
            bus.IncrementPC = 1'b1;
            bus.Zin         = 1'b1;
            state_d         = S_T1;
         end
         S_T1: begin
            bus.Run    = 1'b1;
            bus.ZLOout = 1'b1;
            bus.PCin   = 1'b1;
            bus.Read   = 1'b1;
            bus.MDRin  = 1'b1;
            state_d    = S_T2;
         end
         S_T2: begin
            bus.Run    = 1'b1;
            bus.MDRout = 1'b1;
            bus.IRin   = 1'b1;
            if (is_alu || is_md) begin
               state_d = S_T3;
            end else if (is_halt) begin
               state_d = S_HALT;
            end else begin
               state_d = boundary_next;
            end
         end
         S_T3: begin
            bus.Run  = 1'b1;
            bus.Grb  = 1'b1;
            bus.Rout = 1'b1;
            bus.Yin  = 1'b1;
            state_d  = S_T4;
         end
         S_T4: begin
            bus.Run        = 1'b1;
            bus.Grc        = 1'b1;
            bus.Rout       = 1'b1;
            bus.Zin        = 1'b1;
            bus.ALUControl = op;
            state_d        = S_T5;
         end
         S_T5: begin
            bus.Run = 1'b1;
            if (is_md) begin
               bus.ZLOout = 1'b1;
               bus.LOin   = 1'b1;
               state_d    = S_T6;
            end else if (is_alu) begin
               bus.ZLOout = 1'b1;
               bus.Gra    = 1'b1;
               bus.Rin    = 1'b1;
               state_d    = boundary_next;
            end else begin
               // IR changed class under us; abandon without a writeback.
               state_d = boundary_next;
            end
         end
         S_T6: begin
            bus.Run    = 1'b1;
            bus.ZHIout = 1'b1;
            bus.HIin   = 1'b1;
            state_d    = boundary_next;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_RESET;
         end
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

   logic Clock = 1'b0;
   logic Clear = 1'b0;
   always #5 Clock = ~Clock;

   control_sequencer_if bus ();

   control_sequencer dut (
      .Clock (Clock),
      .Clear (Clear),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [3:0] st;
      logic       run;
      logic       pc_out;
      logic       zhi_out;
      logic       zlo_out;
      logic       mdr_out;
      logic       mar_in;
      logic       z_in;
      logic       pc_in;
      logic       mdr_in;
      logic       ir_in;
      logic       y_in;
      logic       hi_in;
      logic       lo_in;
      logic       inc_pc;
      logic       rd;
      logic       gra;
      logic       grb;
      logic       grc;
      logic       r_in;
      logic       r_out;
      logic [4:0] alu;
   } snap_t;

   snap_t exp_q[$];
   int    exp_end;

   function automatic snap_t observe();
      snap_t s;
      s.st      = bus.State;
      s.run     = bus.Run;
      s.pc_out  = bus.PCout;
      s.zhi_out = bus.ZHIout;
      s.zlo_out = bus.ZLOout;
      s.mdr_out = bus.MDRout;
      s.mar_in  = bus.MARin;
      s.z_in    = bus.Zin;
      s.pc_in   = bus.PCin;
      s.mdr_in  = bus.MDRin;
      s.ir_in   = bus.IRin;
      s.y_in    = bus.Yin;
      s.hi_in   = bus.HIin;
      s.lo_in   = bus.LOin;
      s.inc_pc  = bus.IncrementPC;
      s.rd      = bus.Read;
      s.gra     = bus.Gra;
      s.grb     = bus.Grb;
      s.grc     = bus.Grc;
      s.r_in    = bus.Rin;
      s.r_out   = bus.Rout;
      s.alu     = bus.ALUControl;
      return s;
   endfunction

   function automatic snap_t idle(input int st);
      snap_t s;
      s    = '0;
      s.st = st[3:0];
      return s;
   endfunction

   function automatic snap_t t0_snap();
      snap_t s;
      s        = idle(1);
      s.run    = 1'b1;
      s.pc_out = 1'b1;
      s.mar_in = 1'b1;
      s.inc_pc = 1'b1;
      s.z_in   = 1'b1;
      return s;
   endfunction

   // 0 = ALU, 1 = mul/div, 2 = nop/undefined, 3 = halt
   function automatic int op_class(input logic [4:0] op);
      if (op <= 5'd8) return 0;
      if (op == 5'b01111 || op == 5'b10000) return 1;
      if (op == 5'b11011) return 3;
      return 2;
   endfunction

   task automatic check(input string tag, input snap_t o, input snap_t e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   // Expected per-cycle snapshots for one instruction, plus where it lands afterwards.
   task automatic build(input logic [31:0] ir, input bit stop_end);
      snap_t s;
      int    cls;
      cls = op_class(ir[31:27]);
      exp_q.delete();
      exp_q.push_back(t0_snap());
      s = idle(2); s.run = 1; s.zlo_out = 1; s.pc_in = 1; s.rd = 1; s.mdr_in = 1;
      exp_q.push_back(s);
      s = idle(3); s.run = 1; s.mdr_out = 1; s.ir_in = 1;
      exp_q.push_back(s);
      if (cls <= 1) begin
         s = idle(4); s.run = 1; s.grb = 1; s.r_out = 1; s.y_in = 1;
         exp_q.push_back(s);
         s = idle(5); s.run = 1; s.grc = 1; s.r_out = 1; s.z_in = 1; s.alu = ir[31:27];
         exp_q.push_back(s);
         s = idle(6); s.run = 1; s.zlo_out = 1;
         if (cls == 0) begin s.gra = 1; s.r_in = 1; end
         else s.lo_in = 1;
         exp_q.push_back(s);
         if (cls == 1) begin
            s = idle(7); s.run = 1; s.zhi_out = 1; s.hi_in = 1;
            exp_q.push_back(s);
         end
      end
      if (cls == 3) exp_end = 8;
      else exp_end = stop_end ? 8 : 1;
   endtask

   // Entered and left at a falling edge with the DUT in T0.
   task automatic run_instr(input logic [31:0] ir, input bit stop_end,
                            input int stop_idx, input int clear_idx, input string tag);
      build(ir, stop_end);
      for (int i = 0; i < exp_q.size(); i++) begin
         check($sformatf("%s_c%0d", tag, i), observe(), exp_q[i]);
         if (i == clear_idx) begin
            #2 Clear = 1'b0;
            #1 check({tag, "_clr_now"}, observe(), idle(0));
            for (int k = 0; k < 3; k++) begin
               @(posedge Clock);
               #1 check($sformatf("%s_clr_hold%0d", tag, k), observe(), idle(0));
            end
            @(negedge Clock);
            Clear = 1'b1;
            @(posedge Clock);
            @(negedge Clock);
            check({tag, "_restart"}, observe(), t0_snap());
            exp_end = 1;
            return;
         end
         if (i == 0) bus.IR = $urandom;
         if (i == 1) bus.IR = ir;
         if (i == stop_idx) bus.Stop = 1'b1;
         if (i == exp_q.size() - 1) bus.Stop = stop_end;
         @(posedge Clock);
         @(negedge Clock);
         bus.Stop = 1'b0;
      end
      check({tag, "_end"}, observe(), (exp_end == 1) ? t0_snap() : idle(8));
   endtask

   // From HALT: hold with noisy inputs, then Clear back to T0.
   task automatic halt_hold(input string tag);
      for (int k = 0; k < 20; k++) begin
         bus.IR   = $urandom;
         bus.Stop = 1'($urandom_range(0, 1));
         @(posedge Clock);
         @(negedge Clock);
         check($sformatf("%s_hold%0d", tag, k), observe(), idle(8));
      end
      bus.Stop = 1'b0;
      Clear = 1'b0;
      #1 check({tag, "_clr"}, observe(), idle(0));
      @(posedge Clock);
      #1 check({tag, "_clr_edge"}, observe(), idle(0));
      @(negedge Clock);
      Clear = 1'b1;
      @(posedge Clock);
      @(negedge Clock);
      check({tag, "_restart"}, observe(), t0_snap());
   endtask

   initial begin
      logic [31:0] ir;
      bit          se;
      bus.IR   = 32'h0;
      bus.Stop = 1'b0;
      #1 check("reset", observe(), idle(0));
      repeat (2) @(posedge Clock);
      #1 check("reset_held", observe(), idle(0));
      @(negedge Clock);
      Clear = 1'b1;
      @(posedge Clock);
      @(negedge Clock);

      run_instr(32'h00918000, 1'b0, -1, -1, "add");
      run_instr(32'h80338000, 1'b0, -1, -1, "div");
      run_instr(32'hD0000000, 1'b0, -1, -1, "nop");
      run_instr(32'hF8000000, 1'b0, -1, -1, "undef");
      run_instr(32'h00918000, 1'b0,  3, -1, "stop_t3");
      run_instr(32'h00918000, 1'b1, -1, -1, "add_stop");
      halt_hold("halt_stop");
      run_instr(32'hD8000000, 1'b0, -1, -1, "halt");
      halt_hold("halt_op");
      run_instr(32'h80338000, 1'b0, -1,  4, "div_clear");
      run_instr(32'h78000000, 1'b0, -1, -1, "mul");
      run_instr(32'h40000000, 1'b0, -1, -1, "rol");

      for (int n = 0; n < 40; n++) begin
         ir = $urandom;
         se = ($urandom_range(0, 7) == 0);
         run_instr(ir, se, -1, -1, $sformatf("rnd%0d_op%0d", n, ir[31:27]));
         if (exp_end == 8) halt_hold($sformatf("rnd%0d_halt", n));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
